hpdmc_rdcal: RTL and testbench

//  Read-capture delay calibration engine for the HPDMC DDR datapath, generalised to LANES byte lanes.
//  - Replaces manual idelay_rst/ce/inc control of the per-lane input_delay lines.
//  - Sweeps every tap and reads a known training word through the controller.
//  - Finds each lane's first contiguous passing window and parks that lane's delay at the window centre.
//  - Sits between the HPDMC control interface and the per-lane input_delay instances of the ddrio block.

---
 rtl/hpdmc_rdcal.sv | 195 +++++++++++++++++++
 tb/tb_hpdmc_rdcal.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_rdcal.sv
// Read-capture delay calibration: sweeps every input_delay tap per lane, then parks each lane at its passing-window centre.
// Optional manual idelay pass-through in IDLE when HPDMC_RDCAL_MANUAL_EN is defined.
module hpdmc_rdcal #(
    parameter int unsigned         LANES   = 2,
    parameter int unsigned         LANE_W  = 8,
    parameter int unsigned         TAPS    = 64,
    parameter int unsigned         TAP_W   = 6,
    parameter int unsigned         SETTLE  = 15,
    parameter logic [2*LANE_W-1:0] PATTERN = 16'hA55A
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      cal_start,
    output logic                      cal_busy,
    output logic                      cal_done,
    output logic [LANES-1:0]          cal_fail,
    output logic [LANES*TAP_W-1:0]    cal_tap,
    output logic                      rd_req,
    input  logic                      di_valid,
    input  logic [LANES*2*LANE_W-1:0] di,
    output logic [LANES-1:0]          idelay_rst,
    output logic [LANES-1:0]          idelay_ce,
    output logic [LANES-1:0]          idelay_inc
`ifdef HPDMC_RDCAL_MANUAL_EN
    ,
    input  logic                      man_en,
    input  logic [LANES-1:0]          man_ce,
    input  logic [LANES-1:0]          man_inc,
    input  logic                      man_rst
`endif
);

    localparam int unsigned WORD_W = 2 * LANE_W;
    localparam int unsigned SET_W  = $clog2(SETTLE + 1);

    typedef enum logic [3:0] {
        IDLE, ZERO, SETTLE_S, READ, CHECK, STEP,
        PARK_RST, PARK_SETTLE, PARK_STEP, PARK_GAP, DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [TAP_W-1:0]         tap_q;
    logic [TAP_W-1:0]         park_cnt_q;
    logic [SET_W-1:0]         settle_cnt_q;
    logic [LANES*WORD_W-1:0]  di_q;
    logic [LANES*TAP_W-1:0]   first_q, last_q, target_q;
    logic [LANES-1:0]         open_q, closed_q;
    logic                     rd_req_q, busy_q, done_q;
    logic [LANES-1:0]         fail_q, rst_q, ce_q;
    logic [LANES*TAP_W-1:0]   cal_tap_q;

    logic                     start_ok_c, settle_done_c;
    logic [LANES-1:0]         pass_c, fail_c, rst_d, ce_d;
    logic [LANES*TAP_W-1:0]   target_c;
    logic [TAP_W-1:0]         max_target_c;
    logic [TAP_W:0]           lane_sum_c;

`ifdef HPDMC_RDCAL_MANUAL_EN
    logic man_act_c;
    assign man_act_c  = man_en && (state_q == IDLE);
    assign start_ok_c = cal_start && !man_en;
    assign idelay_rst = man_act_c ? {LANES{man_rst}} : rst_q;
    assign idelay_ce  = man_act_c ? man_ce  : ce_q;
    assign idelay_inc = man_act_c ? man_inc : ce_q;
`else
    assign start_ok_c = cal_start;
    assign idelay_rst = rst_q;
    assign idelay_ce  = ce_q;
    assign idelay_inc = ce_q;
`endif

    assign rd_req   = rd_req_q;
    assign cal_busy = busy_q;
    assign cal_done = done_q;
    assign cal_fail = fail_q;
    assign cal_tap  = cal_tap_q;

    assign settle_done_c = (settle_cnt_q == SET_W'(SETTLE - 1));

    // Per-lane pass flags, window centres and the longest park run
    always_comb begin
        pass_c       = '0;
        fail_c       = '0;
        target_c     = '0;
        max_target_c = '0;
        lane_sum_c   = '0;
        for (int unsigned n = 0; n < LANES; n++) begin
            pass_c[n]  = (di_q[n*WORD_W +: WORD_W] == PATTERN);
            lane_sum_c = (TAP_W+1)'(first_q[n*TAP_W +: TAP_W]) + (TAP_W+1)'(last_q[n*TAP_W +: TAP_W]);
            if (open_q[n] || closed_q[n]) target_c[n*TAP_W +: TAP_W] = lane_sum_c[TAP_W:1];
            else                          fail_c[n] = 1'b1;
            if (target_q[n*TAP_W +: TAP_W] > max_target_c) max_target_c = target_q[n*TAP_W +: TAP_W];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next state plus next values of the registered strobes
    always_comb begin
        state_d = state_q;
        rst_d   = '0;
        ce_d    = '0;
        case (state_q)
            IDLE:        if (start_ok_c) state_d = ZERO;
            ZERO:        state_d = SETTLE_S;
            SETTLE_S:    if (settle_done_c) state_d = READ;
            READ:        if (di_valid) state_d = CHECK;
            CHECK:       state_d = (tap_q == TAP_W'(TAPS - 1)) ? PARK_RST : STEP;
            STEP:        state_d = SETTLE_S;
            PARK_RST:    state_d = PARK_SETTLE;
            PARK_SETTLE: if (settle_done_c) state_d = (max_target_c == '0) ? DONE : PARK_STEP;
            PARK_STEP:   state_d = PARK_GAP;
            PARK_GAP:    state_d = (park_cnt_q == max_target_c) ? DONE : PARK_STEP;
            DONE:        state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        if (state_d == ZERO || state_d == PARK_RST) rst_d = '1;
        if (state_d == STEP) ce_d = '1;
        if (state_d == PARK_STEP) begin
            for (int unsigned n = 0; n < LANES; n++)
                ce_d[n] = (park_cnt_q < target_q[n*TAP_W +: TAP_W]);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rd_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= '0;
            rst_q        <= '0;
            ce_q         <= '0;
            cal_tap_q    <= '0;
            tap_q        <= '0;
            park_cnt_q   <= '0;
            settle_cnt_q <= '0;
            di_q         <= '0;
            first_q      <= '0;
            last_q       <= '0;
            target_q     <= '0;
            open_q       <= '0;
            closed_q     <= '0;
        end else begin
            rd_req_q <= (state_d == READ);
            busy_q   <= (state_d != IDLE);
            rst_q    <= rst_d;
            ce_q     <= ce_d;
            if (state_q == SETTLE_S || state_q == PARK_SETTLE) settle_cnt_q <= settle_cnt_q + SET_W'(1);
            else                                               settle_cnt_q <= '0;
            case (state_q)
                IDLE: if (start_ok_c) begin
                    done_q   <= 1'b0;
                    fail_q   <= '0;
                    tap_q    <= '0;
                    first_q  <= '0;
                    last_q   <= '0;
                    open_q   <= '0;
                    closed_q <= '0;
                end
                READ: if (di_valid) di_q <= di;
                CHECK: begin
                    // Only the first contiguous window is tracked
                    for (int unsigned n = 0; n < LANES; n++) begin
                        if (pass_c[n] && !open_q[n] && !closed_q[n]) begin
                            first_q[n*TAP_W +: TAP_W] <= tap_q;
                            last_q[n*TAP_W +: TAP_W]  <= tap_q;
                            open_q[n]                 <= 1'b1;
                        end else if (pass_c[n] && open_q[n]) begin
                            last_q[n*TAP_W +: TAP_W]  <= tap_q;
                        end else if (!pass_c[n] && open_q[n]) begin
                            open_q[n]   <= 1'b0;
                            closed_q[n] <= 1'b1;
                        end
                    end
                end
                STEP: tap_q <= tap_q + TAP_W'(1);
                PARK_RST: begin
                    target_q   <= target_c;
                    fail_q     <= fail_c;
                    park_cnt_q <= '0;
                end
                PARK_STEP: park_cnt_q <= park_cnt_q + TAP_W'(1);
                DONE: begin
                    done_q    <= 1'b1;
                    cal_tap_q <= target_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hpdmc_rdcal.sv
// Directed bench for hpdmc_rdcal: behavioural delay lines + training-read responder, scoreboarded results.
module tb_hpdmc_rdcal;

    localparam int unsigned LANES  = 2;
    localparam int unsigned LANE_W = 8;
    localparam int unsigned TAPS   = 64;
    localparam int unsigned TAP_W  = 6;
    localparam int unsigned SETTLE = 3;
    localparam logic [15:0] PAT    = 16'hA55A;
    localparam int unsigned BOUND  = TAPS * (SETTLE + 4 + 3) + 2 * TAPS + 8;

    logic                   clk = 1'b0;
    logic                   sys_rst;
    logic                   cal_start;
    logic                   cal_busy, cal_done;
    logic [LANES-1:0]       cal_fail;
    logic [LANES*TAP_W-1:0] cal_tap;
    logic                   rd_req;
    logic                   di_valid;
    logic [31:0]            di;
    logic [LANES-1:0]       idelay_rst, idelay_ce, idelay_inc;
`ifdef HPDMC_RDCAL_MANUAL_EN
    logic                   man_en = 1'b0;
    logic [LANES-1:0]       man_ce = '0;
    logic [LANES-1:0]       man_inc = '0;
    logic                   man_rst = 1'b0;
`endif

    hpdmc_rdcal #(.LANES(LANES), .LANE_W(LANE_W), .TAPS(TAPS), .TAP_W(TAP_W), .SETTLE(SETTLE), .PATTERN(PAT)) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .cal_start(cal_start),
        .cal_busy(cal_busy), .cal_done(cal_done), .cal_fail(cal_fail), .cal_tap(cal_tap),
        .rd_req(rd_req), .di_valid(di_valid), .di(di),
        .idelay_rst(idelay_rst), .idelay_ce(idelay_ce), .idelay_inc(idelay_inc)
`ifdef HPDMC_RDCAL_MANUAL_EN
        , .man_en(man_en), .man_ce(man_ce), .man_inc(man_inc), .man_rst(man_rst)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [5:0] tgt0;
        logic [5:0] tgt1;
        logic [1:0] fail;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mask0, mask1;
    int          tap_m[2];
    int          ce_cnt[2];
    int          rst_cnt;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] range_mask(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    function automatic logic [15:0] lane_word(input logic [63:0] m, input int t);
        if (t >= 0 && t < 64 && m[t]) return PAT;
        return ~PAT;
    endfunction

    // Reference: centre of the first contiguous run of passing taps
    task automatic ref_lane(input logic [63:0] m, output logic [5:0] tgt, output logic fl);
        int f = -1;
        int l = -1;
        for (int t = 0; t < 64; t++) begin
            if (m[t]) begin
                if (f < 0) begin f = t; l = t; end
                else if (l == t - 1) l = t;
            end
        end
        if (f < 0) begin tgt = '0; fl = 1'b1; end
        else begin tgt = 6'((f + l) / 2); fl = 1'b0; end
    endtask

    task automatic push_exp(input string tag);
        exp_t e;
        logic f0, f1;
        e.tag = tag;
        ref_lane(mask0, e.tgt0, f0);
        ref_lane(mask1, e.tgt1, f1);
        e.fail = {f1, f0};
        sb.push_back(e);
    endtask

    task automatic start_run();
        @(negedge clk);
        rst_cnt   = 0;
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
    endtask

    task automatic finish_run();
        int   cyc = 0;
        exp_t e;
        while (!cal_done && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        e = sb.pop_front();
        chk({e.tag, "_done"},  64'(cal_done), 64'(1));
        chk({e.tag, "_busy"},  64'(cal_busy), 64'(0));
        chk({e.tag, "_tap"},   64'(cal_tap),  64'({e.tgt1, e.tgt0}));
        chk({e.tag, "_fail"},  64'(cal_fail), 64'(e.fail));
        chk({e.tag, "_ce0"},   64'(ce_cnt[0]), 64'(e.tgt0));
        chk({e.tag, "_ce1"},   64'(ce_cnt[1]), 64'(e.tgt1));
        chk({e.tag, "_line0"}, 64'(tap_m[0]),  64'(e.tgt0));
        chk({e.tag, "_line1"}, 64'(tap_m[1]),  64'(e.tgt1));
        chk({e.tag, "_rsts"},  64'(rst_cnt),   64'(2));
    endtask

    // Delay-line model and training-read responder
    initial begin
        int wait_cnt = 0;
        bit hold = 1'b0;
        di_valid = 1'b0;
        di       = '0;
        tap_m[0] = 0; tap_m[1] = 0; ce_cnt[0] = 0; ce_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                if (idelay_rst[n]) begin
                    tap_m[n]  = 0;
                    ce_cnt[n] = 0;
                end else if (idelay_ce[n]) begin
                    tap_m[n]  = idelay_inc[n] ? tap_m[n] + 1 : tap_m[n] - 1;
                    ce_cnt[n] = ce_cnt[n] + 1;
                end
            end
            if (idelay_rst != '0) rst_cnt++;
            if (di_valid) begin
                di_valid = 1'b0;
                hold     = 1'b1;
            end else if (!rd_req) begin
                hold     = 1'b0;
                wait_cnt = 0;
            end else if (!hold) begin
                if (wait_cnt == 2) begin
                    di       = {lane_word(mask1, tap_m[1]), lane_word(mask0, tap_m[0])};
                    di_valid = 1'b1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin
        int cyc;
        sys_rst   = 1'b1;
        cal_start = 1'b0;
        rst_cnt   = 0;
        mask0     = '0;
        mask1     = '0;
        repeat (3) @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  64'(cal_busy),   64'(0));
        chk("rst_done",  64'(cal_done),   64'(0));
        chk("rst_fail",  64'(cal_fail),   64'(0));
        chk("rst_tap",   64'(cal_tap),    64'(0));
        chk("rst_rdreq", 64'(rd_req),     64'(0));
        chk("rst_idrst", 64'(idelay_rst), 64'(0));
        chk("rst_idce",  64'(idelay_ce),  64'(0));

        // Both lanes pass in interior windows
        mask0 = range_mask(10, 20);
        mask1 = range_mask(30, 41);
        push_exp("both");
        start_run();
        finish_run();

        // Lane1 never matches
        mask1 = '0;
        push_exp("nolane1");
        start_run();
        finish_run();

        // Second window on lane0 must be ignored
        mask0 = range_mask(0, 4) | range_mask(50, 60);
        mask1 = range_mask(30, 41);
        push_exp("twowin");
        start_run();
        finish_run();

        // Window still open at the last tap
        mask0 = range_mask(58, 63);
        push_exp("topwin");
        start_run();
        finish_run();

        // cal_start pulsed while settling is ignored
        mask0 = range_mask(10, 20);
        push_exp("busystart");
        start_run();
        @(negedge clk);
        chk("busystart_busy", 64'(cal_busy), 64'(1));
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        finish_run();

        // Synchronous reset while waiting on a read
        start_run();
        cyc = 0;
        while (!rd_req && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_rdreq_seen", 64'(rd_req), 64'(1));
        sys_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rdreq", 64'(rd_req),     64'(0));
        chk("abort_busy",  64'(cal_busy),   64'(0));
        chk("abort_idrst", 64'(idelay_rst), 64'(0));
        chk("abort_idce",  64'(idelay_ce),  64'(0));
        chk("abort_idinc", 64'(idelay_inc), 64'(0));
        chk("abort_done",  64'(cal_done),   64'(0));
        @(negedge clk);
        sys_rst = 1'b0;
        repeat (2) @(negedge clk);

        push_exp("rerun");
        start_run();
        finish_run();

`ifdef HPDMC_RDCAL_MANUAL_EN
        // Manual pass-through in IDLE; start is blocked
        @(negedge clk);
        man_en  = 1'b1;
        man_ce  = 2'b01;
        man_inc = 2'b01;
        #1;
        chk("man_ce",  64'(idelay_ce),  64'(2'b01));
        chk("man_inc", 64'(idelay_inc), 64'(2'b01));
        chk("man_rst", 64'(idelay_rst), 64'(2'b00));
        cal_start = 1'b1;
        @(negedge clk);
        cal_start = 1'b0;
        man_ce    = 2'b00;
        @(negedge clk);
        chk("man_nostart", 64'(cal_busy), 64'(0));
        man_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
